// File: rtl/control_config_campos.sv
// control_config_campos: configuration sequencer for the time/date field counters.
// Turns raw mode/up/down/exit buttons into a field-select code, single-cycle
// arriba/abajo pulses with hold-to-repeat, and a one-cycle commit strobe.
// Optional inactivity abort is compiled in with macro CFG_TIMEOUT_EN.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   btn_mode   enter edit / advance field (debounced level, async to clk)
//   btn_up     increment request (debounced level)
//   btn_down   decrement request (debounced level)
//   btn_exit   finish editing early (debounced level)
//   field_sel  0 = none, else code of the field being edited
//   arriba     one-cycle increment pulse
//   abajo      one-cycle decrement pulse
//   editing    high while editing
//   commit     one-cycle strobe, edited values are to be written
//   aborted    one-cycle strobe on inactivity exit (no write)
module control_config_campos #(
  parameter int NUM_FIELDS    = 6,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 13000000,
  parameter int TIMEOUT       = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_exit,
  output logic [3:0] field_sel,
  output logic       arriba,
  output logic       abajo,
  output logic       editing,
  output logic       commit,
  output logic       aborted
);
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  typedef enum logic [1:0] {NONE, UP, DN} dir_t;
  localparam logic [31:0] RD = 32'(REPEAT_DELAY);
  localparam logic [31:0] RE = 32'(REPEAT_DELAY + REPEAT_PERIOD);
  state_t state;
  dir_t dir, dir_nx;
  logic [1:0] sm, su, sd, sx;
  logic pm, pu, pd, px;
  logic [31:0] cnt, cnt_inc, cnt_nx;
  logic me, ue, de, xe, both, held, rep, quiet, up_p, dn_p, to;
  assign me = sm[1] & ~pm;
  assign ue = su[1] & ~pu;
  assign de = sd[1] & ~pd;
  assign xe = sx[1] & ~px;
  // dir remembers which button owns the current hold; it is dropped whenever
  // the hold is disturbed so only a fresh rising edge can start pulses again
  always_comb begin
    both = su[1] & sd[1];
    held = dir == UP ? su[1] & ~sd[1] : dir == DN ? sd[1] & ~su[1] : 1'b0;
    cnt_inc = &cnt ? cnt : cnt + 32'd1;
    rep = held & (cnt_inc == RD | cnt_inc == RE);
    quiet = state != EDIT | me | xe | to | both;
    up_p = ~quiet & (ue | (rep & dir == UP));
    dn_p = ~quiet & (de | (rep & dir == DN));
    dir_nx = quiet ? NONE : ue ? UP : de ? DN : held ? dir : NONE;
    cnt_nx = quiet | ue | de | ~held ? '0 : cnt_inc == RE ? RD : cnt_inc;
  end
`ifdef CFG_TIMEOUT_EN
  logic [31:0] idle;
  logic act;
  assign act = me | xe | ue | de | (rep & ~both);
  assign to = state == EDIT & ~act & idle == 32'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) idle <= '0;
    else idle <= state != EDIT | act ? '0 : idle + 32'd1;
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sm, su, sd, sx, pm, pu, pd, px} <= '0;
      state <= IDLE;
      dir <= NONE;
      cnt <= '0;
      field_sel <= '0;
      {arriba, abajo, editing, commit, aborted} <= '0;
    end else begin
      sm <= {sm[0], btn_mode};
      su <= {su[0], btn_up};
      sd <= {sd[0], btn_down};
      sx <= {sx[0], btn_exit};
      {pm, pu, pd, px} <= {sm[1], su[1], sd[1], sx[1]};
      dir <= dir_nx;
      cnt <= cnt_nx;
      arriba <= up_p;
      abajo <= dn_p;
      commit <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: if (me) begin
          state <= EDIT;
          field_sel <= 4'd1;
          editing <= 1'b1;
        end
        EDIT: if (xe | (me & field_sel == 4'(NUM_FIELDS))) begin
          state <= COMMIT;
          commit <= 1'b1;
          field_sel <= '0;
          editing <= 1'b0;
        end else if (me) field_sel <= field_sel + 4'd1;
        else if (to) begin
          state <= IDLE;
          aborted <= 1'b1;
          field_sel <= '0;
          editing <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_control_config_campos.sv
// tb_control_config_campos: self-checking bench for control_config_campos.
module tb_control_config_campos;
  localparam int NF = 3, RD = 8, RP = 4, TOUT = 40;
  logic clk = 1'b0, reset = 1'b1;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_exit = 1'b0;
  logic [3:0] field_sel;
  logic arriba, abajo, editing, commit, aborted;
  int n_cmp = 0, n_bad = 0;
  control_config_campos #(.NUM_FIELDS(NF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_exit(btn_exit), .field_sel(field_sel), .arriba(arriba), .abajo(abajo),
    .editing(editing), .commit(commit), .aborted(aborted));
  always #5 clk = ~clk;
  // Model: per-edge history of button levels; the synchronised level used at
  // edge j is the level sampled at edge j-2 (zero if within two edges of reset).
  bit h [4][4096];
  bit ed [4096];
  bit ct [4096];
  int e = 0, last_rst = 0, mst = 0, fld = 0;
  logic [8:0] want = '0, got;
`ifdef CFG_TIMEOUT_EN
  int lastref = 0;
`endif
  function automatic bit lv(int k, int j);
    return (j - 2 > last_rst) ? h[k][j-2] : 1'b0;
  endfunction
  // A press yields pulses at offsets 0, RD, RD+RP, ... from its rising edge,
  // provided every cycle since that edge was in EDIT, the other button was low
  // and no mode/exit/timeout event occurred.
  function automatic bit pulse(int k, int o, int j);
    int r, off;
    if (!lv(k, j)) return 1'b0;
    r = j;
    while (lv(k, r - 1)) r--;
    for (int i = r; i <= j; i++) if (!ed[i] || lv(o, i) || ct[i]) return 1'b0;
    off = j - r;
    return off == 0 || (off >= RD && (off - RD) % RP == 0);
  endfunction
  always @(posedge clk) begin : model
    bit me, ue, de, xe, pu, pd, to, com, ab;
    e++;
    if (reset) begin
      last_rst = e; mst = 0; fld = 0; ed[e] = 0; ct[e] = 0; want = '0;
    end else begin
      h[0][e] = btn_mode; h[1][e] = btn_up; h[2][e] = btn_down; h[3][e] = btn_exit;
      me = lv(0, e) && !lv(0, e - 1);
      ue = lv(1, e) && !lv(1, e - 1);
      de = lv(2, e) && !lv(2, e - 1);
      xe = lv(3, e) && !lv(3, e - 1);
      ed[e] = (mst == 1);
      ct[e] = ed[e] && (me || xe);
      pu = pulse(1, 2, e);
      pd = pulse(2, 1, e);
      to = 0; com = 0; ab = 0;
`ifdef CFG_TIMEOUT_EN
      if (ed[e]) begin
        if (me || xe || ue || de || pu || pd) lastref = e + 1;
        else if (e - lastref == TOUT - 1) to = 1;
      end
      if (mst == 0 && me) lastref = e + 1;
      ct[e] = ct[e] || to;
`endif
      case (mst)
        0: if (me) begin mst = 1; fld = 1; end
        1: if (xe || (me && fld == NF)) begin mst = 2; fld = 0; com = 1; end
           else if (me) fld++;
           else if (to) begin mst = 0; fld = 0; ab = 1; end
        default: mst = 0;
      endcase
      want = {4'(fld), mst == 1, com, ab, pu, pd};
    end
    #1;
    if (!reset) begin
      got = {field_sel, editing, commit, aborted, arriba, abajo};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle %0d {field,edit,commit,abort,up,dn}: got %h want %h", e, got, want);
      end
    end
  end
  int sc, n_up, n_dn, n_com, n_ab, max_f, first_up, last_up;
  task automatic chk(input string nm, input int g, input int w);
    n_cmp++;
    if (g != w) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, g, w);
    end
  endtask
  task automatic clr();
    sc = 0; n_up = 0; n_dn = 0; n_com = 0; n_ab = 0; max_f = 0; first_up = -1; last_up = -1;
  endtask
  task automatic step(input bit m, input bit u, input bit d, input bit x);
    btn_mode = m; btn_up = u; btn_down = d; btn_exit = x;
    @(negedge clk);
    if (arriba) begin
      if (n_up == 0) first_up = sc;
      last_up = sc;
      n_up++;
    end
    n_dn += int'(abajo);
    n_com += int'(commit);
    n_ab += int'(aborted);
    if (int'(field_sel) > max_f) max_f = int'(field_sel);
    sc++;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask
  task automatic mode_press();
    step(1, 0, 0, 0);
    idle(3);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({field_sel, editing, commit, aborted, arriba, abajo}), 0);
    reset = 1'b0;
    idle(2);
    clr();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("enter_latency_field", int'(field_sel), 0);
    step(0, 0, 0, 0);
    chk("enter_field", int'(field_sel), 1);
    chk("enter_editing", int'(editing), 1);
    clr();
    for (int i = 0; i < 30; i++) step(0, i < 21, 0, 0);
    chk("hold_up_pulses", n_up, 5);
    chk("hold_up_first", first_up, 2);
    chk("hold_up_last", last_up, 22);
    chk("hold_up_abajo", n_dn, 0);
    clr();
    for (int i = 0; i < 38; i++) step(0, i < 30 || i == 33, i < 20, 0);
    chk("both_pulses_up", n_up, 1);
    chk("both_repress_at", first_up, 35);
    chk("both_pulses_dn", n_dn, 0);
    clr();
    mode_press();
    chk("advance_field2", int'(field_sel), 2);
    clr();
    step(1, 0, 0, 1);
    idle(4);
    chk("exit_mode_commit", n_com, 1);
    chk("exit_mode_max_field", max_f, 2);
    chk("exit_mode_field", int'(field_sel), 0);
    chk("exit_mode_editing", int'(editing), 0);
    idle(2);
    clr();
    mode_press();
    chk("walk_field1", int'(field_sel), 1);
    mode_press();
    chk("walk_field2", int'(field_sel), 2);
    mode_press();
    chk("walk_field3", int'(field_sel), 3);
    mode_press();
    chk("walk_commit_once", n_com, 1);
    chk("walk_field_end", int'(field_sel), 0);
    chk("walk_editing_end", int'(editing), 0);
    chk("walk_max_field", max_f, 3);
    clr();
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    idle(4);
    chk("idle_ignores_buttons", n_up + n_dn + n_com + int'(editing), 0);
    mode_press();
    mode_press();
    chk("pre_reset_field", int'(field_sel), 2);
    step(0, 0, 0, 1);
    reset = 1'b1;
    btn_exit = 1'b0;
    #1;
    chk("async_reset_outputs", int'({field_sel, editing, commit, aborted, arriba, abajo}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clr();
    idle(6);
    chk("reset_no_commit", n_com + n_ab, 0);
    chk("reset_field", int'(field_sel), 0);
    clr();
    step(1, 0, 0, 0);
    idle(104);
`ifdef CFG_TIMEOUT_EN
    chk("timeout_aborted_once", n_ab, 1);
    chk("timeout_no_commit", n_com, 0);
    chk("timeout_field", int'(field_sel), 0);
    chk("timeout_editing", int'(editing), 0);
`else
    chk("no_timeout_editing", int'(editing), 1);
    chk("no_timeout_aborted", n_ab, 0);
    chk("no_timeout_field", int'(field_sel), 1);
    step(0, 0, 0, 1);
    idle(4);
    chk("no_timeout_exit_commit", n_com, 1);
`endif
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
